output_transmitter: RTL and testbench

Serial transmitter for the machine's character output path: it reads a byte held in a data register and shifts it out as an asynchronous serial frame (start bit, c_width data bits LSB first, one stop bit).
- Sits between the output-cell register and the external TX pin.
- The core hands a byte over with a valid/ready handshake.
- The block owns the line until the stop bit completes.

---
 rtl/output_transmitter_pkg.sv | 20 ++
 rtl/output_transmitter_baud_tick.sv | 35 +++
 rtl/output_transmitter.sv | 119 +++++++++++
 tb/tb_output_transmitter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/output_transmitter_pkg.sv
// Shared definitions for the serial output transmitter.
//   tx_state_e : frame FSM states (IDLE, START, DATA, STOP)
//   clog2      : constant ceil(log2(v)) helper for sizing counters
package output_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/output_transmitter_baud_tick.sv
// Bit-time counter for the serial transmitter.
//   i_clock : system clock (rising edge)
//   i_reset : asynchronous active-high reset
//   i_clear : synchronous clear; holds the counter at 0 while asserted
//   o_tick  : high on the last count of each bit time (one cycle)
module output_transmitter_baud_tick
    import output_transmitter_pkg::*;
#(
    parameter int c_clocks_per_bit = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);
    // At least one bit wide so c_clocks_per_bit=1 still gets a legal vector.
    localparam int c_cw = (clog2(c_clocks_per_bit) < 1) ? 1 : clog2(c_clocks_per_bit);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_clocks_per_bit - 1);

    logic [c_cw-1:0] r_count;
    logic            w_last;

    assign w_last = (r_count == c_last);
    assign o_tick = !i_clear && w_last;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_count <= '0;
        else if (i_clear || w_last)
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/output_transmitter.sv
// Asynchronous serial transmitter: start bit, c_width data bits LSB first,
// one stop bit, each held c_clocks_per_bit cycles.
//   i_clock : system clock (rising edge)
//   i_reset : asynchronous active-high reset; abandons any frame in flight
//   i_valid : core offers i_data
//   i_data  : byte to send, sampled only at acceptance
//   o_ready : idle and able to accept a byte
//   o_tx    : serial line, idle high
//   o_busy  : frame in progress
//   o_done  : one-cycle pulse in the first idle cycle after a frame
module output_transmitter
    import output_transmitter_pkg::*;
#(
    parameter int c_width          = 8,
    parameter int c_clocks_per_bit = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [c_width-1:0] i_data,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);
    localparam int c_bw = clog2(c_width + 1);
    localparam logic [c_bw-1:0] c_last_bit = c_bw'(c_width - 1);

    tx_state_e          r_state, w_state_nxt;
    logic [c_width-1:0] r_shift, w_shift_nxt;
    logic [c_bw-1:0]    r_bitcnt, w_bitcnt_nxt;
    logic               r_tx, r_ready, r_busy, r_done;
    logic               w_tx_nxt, w_ready_nxt, w_busy_nxt, w_done_nxt;
    logic               w_tick;

    // Counter sits at 0 while idle, so each frame starts with a full bit time.
    output_transmitter_baud_tick #(
        .c_clocks_per_bit(c_clocks_per_bit)
    ) u_baud (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_clear(r_state == ST_IDLE),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid && r_ready) begin
                    w_state_nxt  = ST_START;
                    w_shift_nxt  = i_data;
                    w_bitcnt_nxt = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt  = ST_DATA;
                    w_bitcnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bitcnt == c_last_bit)
                        w_state_nxt = ST_STOP;
                    else
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they can be registered
        // without adding a cycle of latency to the line.
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
        w_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_tx     <= w_tx_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_tx    = r_tx;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_output_transmitter.sv
module tb_output_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v   = 1'b0;
    logic       sel = 1'b0;   // 0: divider-4 instance, 1: divider-1 instance
    logic [7:0] d   = 8'h00;

    logic a_ready, a_tx, a_busy, a_done;
    logic b_ready, b_tx, b_busy, b_done;
    logic a_valid, b_valid;
    logic s_ready, s_tx, s_busy, s_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign a_valid = v && !sel;
    assign b_valid = v && sel;
    assign s_ready = sel ? b_ready : a_ready;
    assign s_tx    = sel ? b_tx    : a_tx;
    assign s_busy  = sel ? b_busy  : a_busy;
    assign s_done  = sel ? b_done  : a_done;

    output_transmitter #(.c_width(8), .c_clocks_per_bit(4)) u_a (
        .i_clock(clk), .i_reset(rst), .i_valid(a_valid), .i_data(d),
        .o_ready(a_ready), .o_tx(a_tx), .o_busy(a_busy), .o_done(a_done)
    );

    output_transmitter #(.c_width(8), .c_clocks_per_bit(1)) u_b (
        .i_clock(clk), .i_reset(rst), .i_valid(b_valid), .i_data(d),
        .o_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy), .o_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call just after the acceptance edge. Checks ncyc frame cycles; if the
    // whole frame was covered, also checks the done/ready cycle that follows.
    // At cycle mid_k the inputs are re-driven to mid_v/mid_d.
    task automatic frame(input string nm, input logic [7:0] dat, input int ncyc,
                         input int mid_k, input logic mid_v, input logic [7:0] mid_d);
        int         cpb   = sel ? 1 : 4;
        int         total = 10 * cpb;
        logic [9:0] pat   = {1'b1, dat, 1'b0};
        for (int k = 0; k < ncyc && k < total; k++) begin
            @(negedge clk);
            chk($sformatf("%s tx[%0d]", nm, k), s_tx, pat[k / cpb]);
            chk($sformatf("%s busy[%0d]", nm, k), s_busy, 1'b1);
            chk($sformatf("%s ready[%0d]", nm, k), s_ready, 1'b0);
            chk($sformatf("%s done[%0d]", nm, k), s_done, 1'b0);
            if (k == mid_k) begin
                v = mid_v;
                d = mid_d;
            end
            @(posedge clk);
            #1;
        end
        if (ncyc >= total) begin
            @(negedge clk);
            chk({nm, " done pulse"}, s_done, 1'b1);
            chk({nm, " end busy"}, s_busy, 1'b0);
            chk({nm, " end ready"}, s_ready, 1'b1);
            chk({nm, " end tx"}, s_tx, 1'b1);
        end
    endtask

    initial begin
        // Reset state, before release
        #12;
        chk("rst tx", a_tx, 1'b1);
        chk("rst ready", a_ready, 1'b1);
        chk("rst busy", a_busy, 1'b0);
        chk("rst done", a_done, 1'b0);
        chk("rst tx b", b_tx, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Idle line for 100 cycles
        repeat (100) begin
            @(negedge clk);
            chk("idle tx", a_tx, 1'b1);
            chk("idle busy", a_busy, 1'b0);
            chk("idle done", a_done, 1'b0);
        end

        // Single frame 0x41 -> 0,1,0,0,0,0,0,1,0,1
        v = 1'b1; d = 8'h41;
        @(posedge clk); #1;
        v = 1'b0;
        frame("f41", 8'h41, 40, -1, 1'b0, 8'h00);
        @(negedge clk);
        chk("f41 done once", a_done, 1'b0);
        chk("f41 idle tx", a_tx, 1'b1);

        // Back-to-back 0x55 then 0xAA, i_valid held high throughout
        v = 1'b1; d = 8'h55;
        @(posedge clk); #1;
        d = 8'hAA;
        frame("f55", 8'h55, 40, -1, 1'b1, 8'hAA);
        @(posedge clk); #1;   // 0xAA accepted at the edge closing the done cycle
        v = 1'b0;
        frame("fAA", 8'hAA, 40, -1, 1'b0, 8'h00);

        // Busy input: 0x00 in flight, data changed and 0xFF offered mid-frame
        @(negedge clk);
        v = 1'b1; d = 8'h00;
        @(posedge clk); #1;
        v = 1'b0; d = 8'hC3;
        frame("f00", 8'h00, 40, 12, 1'b1, 8'hFF);
        @(posedge clk); #1;
        v = 1'b0;
        frame("fFF", 8'hFF, 40, -1, 1'b0, 8'h00);

        // Reset during data bit 3 of 0x0F
        @(negedge clk);
        v = 1'b1; d = 8'h0F;
        @(posedge clk); #1;
        v = 1'b0;
        frame("f0F", 8'h0F, 18, -1, 1'b0, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("midrst tx", a_tx, 1'b1);
        chk("midrst ready", a_ready, 1'b1);
        chk("midrst busy", a_busy, 1'b0);
        chk("midrst done", a_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("postrst done", a_done, 1'b0);
            chk("postrst tx", a_tx, 1'b1);
        end
        v = 1'b1; d = 8'h33;
        @(posedge clk); #1;
        v = 1'b0;
        frame("f33", 8'h33, 40, -1, 1'b0, 8'h00);

        // Minimum divider: 0x80 -> 0,0,0,0,0,0,0,0,1,1, done 10 cycles later
        sel = 1'b1;
        @(negedge clk);
        v = 1'b1; d = 8'h80;
        @(posedge clk); #1;
        v = 1'b0;
        frame("b80", 8'h80, 10, -1, 1'b0, 8'h00);
        @(negedge clk);
        chk("b80 done once", b_done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
